// File: rtl/mem_arb_pkg.sv
// Shared types and elaboration helpers for mem_port_arbiter.
// The MEM_ARB_RR_EN macro selects round-robin arbitration; without it, arbitration is fixed priority.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Index width for n channels; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic bit nch_ok(input int n);
        return n >= 2;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: request vector plus last-served pointer to winning index.
// The MEM_ARB_RR_EN macro selects round-robin starting after the pointer; without it, the lowest index wins.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IW  = clog2(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [IW-1:0]  i_ptr,
    output logic [IW-1:0]  o_idx,
    output logic           o_vld
);

`ifdef MEM_ARB_RR_EN
    logic [IW-1:0] w_cand;

    // Scan from farthest to nearest so the channel right after the pointer is assigned last and wins.
    always_comb begin
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        for (int k = NCH; k >= 1; k--) begin
            w_cand = IW'((int'(i_ptr) + k) % NCH);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_vld = 1'b1;
            end
        end
    end
`else
    logic          w_unused_ptr;
    logic [IW-1:0] w_cand;

    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            w_cand = IW'(i);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_vld = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NCH requesters onto one shared memory port; FSM IDLE -> ACCESS -> DONE.
// The MEM_ARB_RR_EN macro enables round-robin arbitration (default build: fixed priority, channel 0 highest).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int NCH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    done,
    output logic [DW-1:0]     rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ready
);

    localparam int IW = clog2(NCH);

    if (!nch_ok(NCH)) begin : g_nch_check
        $error("mem_port_arbiter: NCH must be at least 2");
    end

    arb_state_t    r_state;
    logic [IW-1:0] w_idx;
    logic          w_vld;
    logic [IW-1:0] w_ptr;
    logic [AW-1:0] w_addr  [NCH];
    logic [DW-1:0] w_wdata [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign w_addr[g]  = addr[g*AW +: AW];
        assign w_wdata[g] = wdata[g*DW +: DW];
    end

    mem_arb_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .i_req (req),
        .i_ptr (w_ptr),
        .o_idx (w_idx),
        .o_vld (w_vld)
    );

`ifdef MEM_ARB_RR_EN
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_idx;

    // Pointer starts at the last channel so channel 0 is searched first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IW'(NCH - 1);
            r_idx <= '0;
        end else begin
            if (r_state == IDLE && w_vld) r_idx <= w_idx;
            if (r_state == DONE)          r_ptr <= r_idx;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            gnt       <= '0;
            done      <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_vld) begin
                        mem_addr  <= w_addr[w_idx];
                        mem_wdata <= w_wdata[w_idx];
                        mem_we    <= we[w_idx];
                        mem_en    <= 1'b1;
                        gnt       <= NCH'(1) << w_idx;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Address and write data stay frozen until the memory acknowledges.
                    if (mem_ready) begin
                        rdata   <= mem_rdata;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= gnt;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= '0;
                    gnt     <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with NCH=3: directed cases plus randomized traffic vs a transaction model.
// Expected arbitration order follows MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NCH = 3;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH-1:0]    gnt;
    logic [NCH-1:0]    done;
    logic [DW-1:0]     rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW  (AW),
        .DW  (DW),
        .NCH (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Transaction model: at most one access in flight; phase 0 = port free,
    // 1 = waiting on memory, 2 = completion cycle.
    int             m_phase = 0;
    int             m_owner = 0;
    int             m_last  = NCH - 1;
    int             m_win;
    logic [NCH-1:0] e_gnt   = '0;
    logic [NCH-1:0] e_done  = '0;
    logic           e_en    = 1'b0;
    logic           e_we    = 1'b0;
    logic [AW-1:0]  e_addr  = '0;
    logic [DW-1:0]  e_wdata = '0;
    logic [DW-1:0]  e_rdata = '0;

    function automatic int model_pick(input logic [NCH-1:0] r, input int last);
        int base;
        int c;
        base = RR ? last : NCH - 1;
        for (int k = 1; k <= NCH; k++) begin
            c = (base + k) % NCH;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_last = NCH - 1;
            e_gnt = '0; e_done = '0; e_en = 1'b0; e_we = 1'b0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
        end else if (m_phase == 0) begin
            m_win = model_pick(req, m_last);
            if (m_win >= 0) begin
                m_owner = m_win;
                m_phase = 1;
                e_gnt   = '0;
                e_gnt[m_win] = 1'b1;
                e_en    = 1'b1;
                e_we    = we[m_win];
                e_addr  = addr[m_win*AW +: AW];
                e_wdata = wdata[m_win*DW +: DW];
            end
        end else if (m_phase == 1) begin
            if (mem_ready) begin
                e_rdata = mem_rdata;
                e_en    = 1'b0;
                e_we    = 1'b0;
                e_done  = e_gnt;
                m_phase = 2;
            end
        end else begin
            e_done  = '0;
            e_gnt   = '0;
            m_last  = m_owner;
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ({gnt, done, mem_en, mem_we, mem_addr, mem_wdata, rdata} !==
                {e_gnt, e_done, e_en, e_we, e_addr, e_wdata, e_rdata}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got/want gnt=%b/%b done=%b/%b en=%b/%b we=%b/%b addr=%h/%h wdata=%h/%h rdata=%h/%h",
                         $time, gnt, e_gnt, done, e_done, mem_en, e_en, mem_we, e_we,
                         mem_addr, e_addr, mem_wdata, e_wdata, rdata, e_rdata);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output logic [NCH-1:0] g);
        int n;
        n = 0;
        while (gnt == '0 && n < 20) begin
            tick();
            n++;
        end
        if (gnt == '0) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got %b want nonzero", gnt);
        end
        g = gnt;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (gnt != '0 && n < 20) begin
            tick();
            n++;
        end
        if (gnt != '0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %b want 000", gnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] seen;
        logic [NCH-1:0] exp_seq [4];
        if (RR) exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        else    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001};

        req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt",   64'(gnt),    64'(0));
        check("rst_en",    64'(mem_en), 64'(0));
        check("rst_done",  64'(done),   64'(0));
        check("rst_addr",  64'(mem_addr), 64'(0));
        rst_n = 1'b1;
        tick();

        // Contention with every channel requesting.
        mem_ready = 1'b1; mem_rdata = 32'h0000_0001; req = '1;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(seen);
            check("cont_gnt", 64'(seen), 64'(exp_seq[n]));
            wait_idle();
        end
        req = '0;
        tick();

        // Single read from channel 0.
        addr[0 +: AW] = 32'h0000_0040; mem_rdata = 32'h1234_5678; mem_ready = 1'b1; req = 3'b001;
        tick();
        check("rd_en",    64'(mem_en),   64'(1));
        check("rd_we",    64'(mem_we),   64'(0));
        check("rd_addr",  64'(mem_addr), 64'(32'h40));
        check("rd_gnt",   64'(gnt),      64'(3'b001));
        tick();
        check("rd_done",  64'(done),     64'(3'b001));
        check("rd_rdata", 64'(rdata),    64'(32'h1234_5678));
        check("rd_en_off", 64'(mem_en),  64'(0));
        req = '0;
        tick();
        check("rd_idle_gnt", 64'(gnt),   64'(0));
        check("rd_pulse",    64'(done),  64'(0));
        check("rd_hold",     64'(rdata), 64'(32'h1234_5678));

        // Write from channel 1 with three wait states.
        mem_ready = 1'b0; mem_rdata = 32'hCAFE_F00D; we = 3'b010;
        addr[AW +: AW] = 32'h0000_0100; wdata[DW +: DW] = 32'hDEAD_BEEF; req = 3'b010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr_en",    64'(mem_en),    64'(1));
            check("wr_we",    64'(mem_we),    64'(1));
            check("wr_addr",  64'(mem_addr),  64'(32'h100));
            check("wr_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
            check("wr_nodone", 64'(done),     64'(0));
            if (i == 3) mem_ready = 1'b1;
        end
        tick();
        check("wr_done", 64'(done), 64'(3'b010));
        req = '0; we = '0; mem_ready = 1'b0;
        tick();
        tick();

        // Channel 0 drops its request mid-access.
        req = 3'b001;
        tick();
        check("drop_gnt", 64'(gnt), 64'(3'b001));
        req = '0;
        tick();
        mem_ready = 1'b1;
        tick();
        check("drop_done", 64'(done), 64'(3'b001));
        tick();
        tick();
        check("drop_idle_gnt", 64'(gnt),    64'(0));
        check("drop_idle_en",  64'(mem_en), 64'(0));

        // Reset asserted in the middle of an access.
        mem_ready = 1'b0; req = 3'b001;
        tick();
        check("ra_en_before", 64'(mem_en), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("ra_en",    64'(mem_en), 64'(0));
        check("ra_gnt",   64'(gnt),    64'(0));
        check("ra_done",  64'(done),   64'(0));
        check("ra_rdata", 64'(rdata),  64'(0));
        tick();
        rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        tick();
        check("ra_after_gnt",  64'(gnt),   64'(3'b001));
        tick();
        check("ra_after_done", 64'(done),  64'(3'b001));
        check("ra_after_data", 64'(rdata), 64'(32'h0BAD_CAFE));
        req = '0;
        tick();
        tick();

        // Randomized traffic; requests are held until their done pulse.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                if (done[i])      req[i] = ($urandom_range(0, 1) == 1);
                else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
            end
            we        = NCH'($urandom);
            addr      = {$urandom, $urandom, $urandom};
            wdata     = {$urandom, $urandom, $urandom};
            mem_rdata = $urandom;
            mem_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        req = '0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
